needs_controller: RTL and testbench
===================================

Name: needs_controller

Overview:
- Owns the six 4-bit need levels: hunger, happiness, health, hygiene, energy, social. 0 = fully satisfied, 15 = worst.
- Drives the status-evaluation block downstream.
- Ages one need per decay tick in round-robin order.
- Serves care actions (feed, play, medicine, clean, sleep, socialise) over a valid/ready handshake, one at a time.
- Latches a terminal dead state when hunger reaches 15.

Parameters:
- TICK_DIV, 50000000, clk cycles per decay tick (>=2).
- ACTION_DEC, 4, amount subtracted from the targeted need per action (1..15).
- ACTION_BUSY, 8, busy cycles after an action is applied, during which no new action is accepted (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- act_valid  in  1  care action request.
- act_id  in  3  0 feed->hunger, 1 play->happiness, 2 medicine->health, 3 clean->hygiene, 4 sleep->energy, 5 socialise->social; 6,7 reserved.
- act_ready  out  1  action can be accepted this cycle.
- hunger, happiness, health, hygiene, energy, social  out  4 each  registered need levels.
- busy  out  1  high in APPLY or BUSY.
- dead  out  1  terminal state flag.

Behaviour:
- Reset (reset=0, async): all needs 0, prescaler 0, round-robin pointer 0, pending 0, state IDLE, busy 0, dead 0.
- act_ready is combinational: 1 only in IDLE and not dead, so it is 1 in the first cycle after reset release.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse on wrap.
  - Runs in IDLE, APPLY and BUSY; frozen in DEAD.
- Decay:
  - Applied only in IDLE: when tick or pending, need[ptr] <= min(need[ptr]+1, 15).
  - ptr advances 0->1->...->5->0 whether or not the need saturated; pending clears.
  - A tick in APPLY/BUSY sets pending; multiple ticks collapse to one.
- Handshake:
  - Transfer occurs when act_valid && act_ready.
  - Valid ids 0..5: capture id, go to APPLY next cycle.
  - Ids 6,7: accepted and dropped; state stays IDLE; no need changes.
- Simultaneous decay and transfer in IDLE: decay applies that cycle; the action applies in the following APPLY cycle.
- FSM:
  - IDLE: decay/handshake as above.
  - APPLY (1 cycle): need[id] <= (need[id] >= ACTION_DEC) ? need[id]-ACTION_DEC : 0. Then go to BUSY with busy counter = ACTION_BUSY-1.
  - BUSY: counter decrements; at 0 return to IDLE.
  - DEAD: all needs, ptr and prescaler frozen; dead=1, act_ready=0, busy=0. Exit only via reset.
- Death:
  - Checked on registered hunger every cycle: if hunger==15 in any state, the next state is DEAD (checked before all other transitions).
  - The pending action is discarded.
- Latency:
  - Transfer to updated need output: 2 cycles.
  - Transfer to next act_ready: ACTION_BUSY+2 cycles.
- All arithmetic is 4-bit saturating; no wrap-around is ever visible.
- Reset asserted mid-APPLY/BUSY: immediate return to reset values; the in-flight action is lost.

Optional Feature:
- SLEEP_HALT_EN.
- Defined: a sleep action (id 4) loads the BUSY counter with 4*ACTION_BUSY-1, and the prescaler and pending flag are held (no new ticks) for that sleep's APPLY and BUSY cycles.
- Undefined: sleep behaves like every other action.

Decomposition:
- Shared package (needs_pkg): the need index constants (NEED_HUNGER=0 .. NEED_SOCIAL=5), NEED_MAX=15, the 4-bit need level typedef, and the FSM state enum (IDLE, APPLY, BUSY, DEAD).
- One sub-module: tick_prescaler (counter with enable, tick output), reusable by other timing blocks.

Test Plan:
- Decay: TICK_DIV=4, no actions, 24 cycles after reset -> each need = 1, applied in order hunger, happiness, ..., social.
- Action: ACTION_DEC=4, ACTION_BUSY=8, hunger=9, feed transfer at cycle T -> hunger=5 at T+2, act_ready low T+1..T+9, high at T+10.
- Saturation: hygiene=2, clean -> 0; social=15 on a decay tick -> stays 15, ptr still advances.
- Pending: two ticks during BUSY -> exactly one increment on the first IDLE cycle, at the current ptr.
- Death: hunger=14, tick hits hunger -> hunger=15, next cycle dead=1, act_ready=0; further act_valid and ticks change nothing until reset, after which all outputs = 0.
- Reserved id 7 accepted -> no need change, act_ready stays 1. Reset pulsed mid-BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/needs_pkg.sv
// Shared types and constants for the pet-needs controller: need indices, level type, FSM states.
package needs_pkg;

  localparam int unsigned NEED_W    = 4;
  localparam int unsigned NUM_NEEDS = 6;
  localparam int unsigned ACT_ID_W  = 3;
  localparam int unsigned PTR_W     = 3;

  localparam int unsigned NEED_HUNGER    = 0;
  localparam int unsigned NEED_HAPPINESS = 1;
  localparam int unsigned NEED_HEALTH    = 2;
  localparam int unsigned NEED_HYGIENE   = 3;
  localparam int unsigned NEED_ENERGY    = 4;
  localparam int unsigned NEED_SOCIAL    = 5;

  typedef logic [NEED_W-1:0]   need_t;
  typedef logic [ACT_ID_W-1:0] act_id_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  localparam need_t NEED_MAX = NEED_W'(15);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    BUSY  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  // Saturating helpers keep every need inside 0..NEED_MAX.
  function automatic need_t sat_inc(input need_t v);
    return (v == NEED_MAX) ? v : v + NEED_W'(1);
  endfunction

  function automatic need_t sat_sub(input need_t v, input need_t d);
    return (v >= d) ? v - d : '0;
  endfunction

endpackage

// File: rtl/needs_controller_if.sv
// Care-action request handshake between the action source and the needs controller.
interface needs_controller_if;
  import needs_pkg::*;

  logic    act_valid;
  act_id_t act_id;
  logic    act_ready;

  modport master (output act_valid, output act_id, input act_ready);
  modport slave  (input act_valid, input act_id, output act_ready);

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider with enable; tick_c pulses for one cycle as the count wraps.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tick_c = en && (cnt == LAST);

endmodule

// File: rtl/needs_controller.sv
// Owns six need levels: round-robin decay, handshaked care actions, terminal death on max hunger.
// Optional build macro SLEEP_HALT_EN: sleep busies 4x longer and halts decay ticking meanwhile.
module needs_controller
  import needs_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ACTION_DEC  = 4,
  parameter int unsigned ACTION_BUSY = 8
) (
  input  logic clk,
  input  logic reset,
  needs_controller_if.slave act,
  output need_t hunger,
  output need_t happiness,
  output need_t health,
  output need_t hygiene,
  output need_t energy,
  output need_t social,
  output logic  busy,
  output logic  dead
);

`ifdef SLEEP_HALT_EN
  localparam int unsigned BUSY_MAX = 4 * ACTION_BUSY - 1;
`else
  localparam int unsigned BUSY_MAX = ACTION_BUSY - 1;
`endif
  localparam int unsigned BCNT_W = (BUSY_MAX > 0) ? $clog2(BUSY_MAX + 1) : 1;
  localparam need_t NEED_DEC = NEED_W'(ACTION_DEC);

  state_t            state;
  state_t            state_next;
  need_t             needs [NUM_NEEDS];
  ptr_t              ptr;
  logic              pending;
  act_id_t           act_id_q;
  logic [BCNT_W-1:0] bcnt;
  logic [BCNT_W-1:0] bcnt_load_c;

  logic tick_c;
  logic presc_en_c;
  logic halt_c;
  logic death_c;
  logic in_action_c;
  logic xfer_c;
  logic decay_c;
  logic apply_c;

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk    (clk),
    .rst_n  (reset),
    .en     (presc_en_c),
    .tick_c (tick_c)
  );

  // Prescaler gating: frozen once dead, and optionally while a sleep is in progress.
  always_comb begin
    in_action_c = 1'b0;
    halt_c      = 1'b0;
    presc_en_c  = 1'b0;
    in_action_c = (state == APPLY) || (state == BUSY);
`ifdef SLEEP_HALT_EN
    halt_c = in_action_c && (act_id_q == ACT_ID_W'(NEED_ENERGY));
`endif
    presc_en_c = (state != DEAD) && !halt_c;
  end

  // FSM output decode; death pre-empts decay and action application.
  always_comb begin
    act.act_ready = 1'b0;
    death_c       = 1'b0;
    xfer_c        = 1'b0;
    decay_c       = 1'b0;
    apply_c       = 1'b0;
    death_c       = (needs[NEED_HUNGER] == NEED_MAX);
    act.act_ready = (state == IDLE) && !dead;
    xfer_c        = act.act_valid && act.act_ready;
    decay_c       = (state == IDLE) && !death_c && (tick_c || pending);
    apply_c       = (state == APPLY) && !death_c;
  end

  always_comb begin
    state_next = state;
    if (death_c) begin
      state_next = DEAD;
    end else begin
      case (state)
        IDLE:    if (xfer_c && (act.act_id < ACT_ID_W'(NUM_NEEDS))) state_next = APPLY;
        APPLY:   state_next = BUSY;
        BUSY:    if (bcnt == '0) state_next = IDLE;
        DEAD:    state_next = DEAD;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      dead  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == APPLY) || (state_next == BUSY);
      dead  <= (state_next == DEAD);
    end
  end

  always_comb begin
    bcnt_load_c = BCNT_W'(ACTION_BUSY - 1);
`ifdef SLEEP_HALT_EN
    if (act_id_q == ACT_ID_W'(NEED_ENERGY)) bcnt_load_c = BCNT_W'(4 * ACTION_BUSY - 1);
`endif
  end

  // Need levels, decay pointer, deferred-tick flag and the captured action.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEEDS; i++) needs[i] <= '0;
      ptr      <= '0;
      pending  <= 1'b0;
      act_id_q <= '0;
      bcnt     <= '0;
    end else begin
      for (int i = 0; i < NUM_NEEDS; i++) begin
        if (decay_c && (ptr == PTR_W'(i))) needs[i] <= sat_inc(needs[i]);
        if (apply_c && (act_id_q == ACT_ID_W'(i))) needs[i] <= sat_sub(needs[i], NEED_DEC);
      end
      if (decay_c) ptr <= (ptr == PTR_W'(NUM_NEEDS - 1)) ? '0 : ptr + PTR_W'(1);
      if (decay_c) begin
        pending <= 1'b0;
      end else if (tick_c && in_action_c) begin
        pending <= 1'b1;
      end
      if (xfer_c) act_id_q <= act.act_id;
      if (state == APPLY) begin
        bcnt <= bcnt_load_c;
      end else if ((state == BUSY) && (bcnt != '0)) begin
        bcnt <= bcnt - BCNT_W'(1);
      end
    end
  end

  assign hunger    = needs[NEED_HUNGER];
  assign happiness = needs[NEED_HAPPINESS];
  assign health    = needs[NEED_HEALTH];
  assign hygiene   = needs[NEED_HYGIENE];
  assign energy    = needs[NEED_ENERGY];
  assign social    = needs[NEED_SOCIAL];

endmodule

// File: tb/tb_needs_controller.sv
// Self-checking bench for needs_controller: directed scenarios plus random actions against a cycle model.
module tb_needs_controller;
  import needs_pkg::*;

  localparam int TD = 4;
  localparam int AD = 4;
  localparam int AB = 8;

  logic  clk = 1'b0;
  logic  reset;
  need_t hunger, happiness, health, hygiene, energy, social;
  logic  busy, dead;

  needs_controller_if act_if ();

  needs_controller #(.TICK_DIV(TD), .ACTION_DEC(AD), .ACTION_BUSY(AB)) dut (
    .clk       (clk),
    .reset     (reset),
    .act       (act_if),
    .hunger    (hunger),
    .happiness (happiness),
    .health    (health),
    .hygiene   (hygiene),
    .energy    (energy),
    .social    (social),
    .busy      (busy),
    .dead      (dead)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: need levels plus "cycles left until the next action can be taken".
  int m_need [6];
  int m_ptr, m_presc, m_left, m_len, m_act;
  bit m_pend, m_dead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int action_len(input int id);
`ifdef SLEEP_HALT_EN
    if (id == 4) return 4 * AB + 1;
`endif
    return AB + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_need[i] = 0;
    m_ptr = 0; m_presc = 0; m_left = 0; m_len = 0; m_act = 0;
    m_pend = 0; m_dead = 0;
  endtask

  // One clock edge of the pet's life, given the request presented during the cycle.
  task automatic model_step(input bit v, input int id);
    bit halt, tick;
    halt = 0;
`ifdef SLEEP_HALT_EN
    halt = (m_left > 0) && (m_act == 4);
`endif
    tick = !m_dead && !halt && (m_presc == TD - 1);
    if (!m_dead && !halt) m_presc = (m_presc + 1) % TD;
    if (m_dead) return;
    if (m_need[0] == 15) begin
      m_dead = 1;
      m_left = 0;
      return;
    end
    if (m_left == 0) begin
      if (tick || m_pend) begin
        m_need[m_ptr] = (m_need[m_ptr] < 15) ? m_need[m_ptr] + 1 : 15;
        m_ptr  = (m_ptr + 1) % 6;
        m_pend = 0;
      end
      if (v && id < 6) begin
        m_act  = id;
        m_left = action_len(id);
        m_len  = m_left;
      end
    end else begin
      if (m_left == m_len) m_need[m_act] = (m_need[m_act] >= AD) ? m_need[m_act] - AD : 0;
      if (tick) m_pend = 1;
      m_left--;
    end
  endtask

  task automatic check_all();
    need_t o [6];
    o = '{hunger, happiness, health, hygiene, energy, social};
    for (int i = 0; i < 6; i++) chk($sformatf("need%0d", i), 32'(o[i]), 32'(m_need[i]));
    chk("busy",  32'(busy),             32'(m_left > 0));
    chk("dead",  32'(dead),             32'(m_dead));
    chk("ready", 32'(act_if.act_ready), 32'(!m_dead && m_left == 0));
  endtask

  task automatic cycle(input bit v, input int id);
    check_all();
    act_if.act_valid = v;
    act_if.act_id    = 3'(id);
    model_step(v, id);
    @(negedge clk);
    act_if.act_valid = 1'b0;
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hunger"}, 32'(hunger), 0);
    chk({tag, "_happy"},  32'(happiness), 0);
    chk({tag, "_health"}, 32'(health), 0);
    chk({tag, "_hyg"},    32'(hygiene), 0);
    chk({tag, "_energy"}, 32'(energy), 0);
    chk({tag, "_social"}, 32'(social), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_dead"},   32'(dead), 0);
  endtask

  task automatic do_reset(input string tag);
    act_if.act_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    act_if.act_valid = 1'b0;
    act_if.act_id    = '0;
    #1;
    do_reset("por");
    chk("ready_after_reset", 32'(act_if.act_ready), 1);

    // Pure decay: one increment per need in order over 24 cycles.
    for (int k = 0; k < 24; k++) cycle(0, 0);
    chk("decay_hunger", 32'(hunger), 1);
    chk("decay_happy",  32'(happiness), 1);
    chk("decay_social", 32'(social), 1);

    // Let hunger climb to 9, then feed and check the latencies.
    n = 0;
    while (m_need[0] != 9 && n < 1000) begin cycle(0, 0); n++; end
    chk("h9_reached", 32'(hunger), 9);
    cycle(1, 0);
    chk("feed_ready_t1", 32'(act_if.act_ready), 0);
    chk("feed_busy_t1",  32'(busy), 1);
    cycle(0, 0);
    chk("feed_hunger_t2", 32'(hunger), 5);
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("feed_ready_t%0d", k), 32'(act_if.act_ready), 0);
      cycle(0, 0);
    end
    chk("feed_ready_t10", 32'(act_if.act_ready), 1);

    // Reserved id is swallowed without leaving IDLE.
    cycle(1, 7);
    chk("rsvd_ready", 32'(act_if.act_ready), 1);
    chk("rsvd_busy",  32'(busy), 0);

    // Reset in the middle of a clean action.
    cycle(1, 3);
    for (int k = 0; k < 4; k++) cycle(0, 0);
    chk("midbusy_busy", 32'(busy), 1);
    do_reset("midbusy");
    chk("midbusy_ready", 32'(act_if.act_ready), 1);

    // Random care actions, feeding biased so the pet lives a while.
    for (int k = 0; k < 4000; k++) begin
      if (m_dead && ($urandom % 16 == 0)) begin
        do_reset("rand_rst");
      end else begin
        bit v;
        int id;
        v  = ($urandom % 3 == 0);
        id = ($urandom % 3 == 0) ? 0 : int'($urandom % 8);
        cycle(v, id);
      end
    end

    // Neglect until death, then verify nothing moves.
    if (m_dead) do_reset("pre_death");
    n = 0;
    while (!m_dead && n < 2000) begin cycle(0, 0); n++; end
    cycle(0, 0);
    chk("death_flag",   32'(dead), 1);
    chk("death_ready",  32'(act_if.act_ready), 0);
    chk("death_hunger", 32'(hunger), 15);
    chk("death_busy",   32'(busy), 0);
    for (int k = 0; k < 40; k++) cycle(1'($urandom % 2), int'($urandom % 8));
    chk("dead_frozen_hunger", 32'(hunger), 15);
    chk("dead_frozen_flag",   32'(dead), 1);
    do_reset("post_death");
    chk("post_death_ready", 32'(act_if.act_ready), 1);
    for (int k = 0; k < 8; k++) cycle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
